// File: rtl/mmio_timer_if.sv
// CPU data-path bus seen by the memory-mapped timer: address, store data,
// strobes, and the combinational hit/read-data return path.
interface mmio_timer_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        memwrite;
    logic        memread;
    logic        hit;
    logic [31:0] rdata;

    modport master (output addr, wdata, memwrite, memread, input  hit, rdata);
    modport slave  (input  addr, wdata, memwrite, memread, output hit, rdata);
endinterface

// File: rtl/mmio_timer.sv
// Two-channel 16-bit down-counting timer/counter on a 6-word MMIO window.
// Reads are combinational; STATUS reads clear the sticky done bit.
module mmio_timer #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FC20
) (
    input  logic        clock,
    input  logic        reset,
    mmio_timer_if.slave bus,
    input  logic [1:0]  pulse_in,
    output logic        irq
);
    localparam int NUM_CH = 2;

    logic [2:0]              off;
    logic                    hit_w;
    logic [31:0]             rdata_w;
    logic [NUM_CH-1:0][15:0] load_q, count_q;
    logic [NUM_CH-1:0]       mode_q, rpt_q, ie_q, run_q, done_q;
    logic [NUM_CH-1:0]       sync1_q, sync2_q, sync3_q, edge_q;
    logic [NUM_CH-1:0]       wr_ctrl, wr_load, rd_stat, tick;

    assign off   = bus.addr[4:2];
    assign hit_w = (bus.addr[31:5] == BASE_ADDR[31:5]) && (off <= 3'd5);

    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            wr_ctrl[ch] = bus.memwrite && hit_w && (off == 3'(ch));
            wr_load[ch] = bus.memwrite && hit_w && (off == 3'(ch + 2));
            rd_stat[ch] = bus.memread  && hit_w && (off == 3'(ch));
            tick[ch]    = mode_q[ch] ? edge_q[ch] : 1'b1;
        end
    end

    // off[0] selects the channel in every register pair
    always_comb begin
        rdata_w = '0;
        if (hit_w) begin
            case (off[2:1])
                2'd0:    rdata_w[3:0]  = {rpt_q[off[0]], mode_q[off[0]],
                                          run_q[off[0]], done_q[off[0]]};
                2'd1:    rdata_w[15:0] = load_q[off[0]];
                default: rdata_w[15:0] = count_q[off[0]];
            endcase
        end
    end

    assign bus.hit   = hit_w;
    assign bus.rdata = rdata_w;

    always_ff @(posedge clock) begin
        if (reset) begin
            load_q  <= '0;
            count_q <= '0;
            mode_q  <= '0;
            rpt_q   <= '0;
            ie_q    <= '0;
            run_q   <= '0;
            done_q  <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
            edge_q  <= '0;
            irq     <= 1'b0;
        end else begin
            // registered edge detect puts the counter tick 3 edges after the sampled rise
            sync1_q <= pulse_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            edge_q  <= sync2_q & ~sync3_q;
            irq     <= |(done_q & ie_q);
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (wr_load[ch]) load_q[ch] <= bus.wdata[15:0];
                // clear first so a same-edge set below overrides it
                if (rd_stat[ch]) done_q[ch] <= 1'b0;
                if (wr_ctrl[ch]) begin
                    mode_q[ch] <= bus.wdata[1];
                    rpt_q[ch]  <= bus.wdata[2];
                    ie_q[ch]   <= bus.wdata[3];
                    if (!bus.wdata[0]) begin
                        run_q[ch] <= 1'b0;
                    end else if (load_q[ch] == 16'd0) begin
                        count_q[ch] <= 16'd0;
                        run_q[ch]   <= 1'b0;
                        done_q[ch]  <= 1'b1;
                    end else begin
                        count_q[ch] <= load_q[ch];
                        run_q[ch]   <= 1'b1;
                    end
                end else if (run_q[ch] && tick[ch]) begin
                    if (count_q[ch] > 16'd1) begin
                        count_q[ch] <= count_q[ch] - 16'd1;
                    end else if (count_q[ch] == 16'd1) begin
                        done_q[ch] <= 1'b1;
                        if (rpt_q[ch]) begin
                            count_q[ch] <= load_q[ch];
                        end else begin
                            count_q[ch] <= 16'd0;
                            run_q[ch]   <= 1'b0;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: doc/mmio_timer.md
# mmio_timer

Memory-mapped two-channel 16-bit timer/counter that sits directly downstream of the single-cycle CPU core's data path, in parallel with the data RAM. It decodes the ALU result address, accepts stores of the register-file operand, and returns read data combinationally in the same cycle as the load. Each channel counts down either on clock cycles (timer mode) or on external pulse edges (counter mode), with sticky done status, optional auto-reload and an interrupt output.

## Interface
- BASE_ADDR, 32'hFFFF_FC20, word-aligned base of the 6-word register window
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock at high resets all state
- addr  in  32  data address (CPU ALU result)
- wdata  in  32  store data (CPU read_data_2); only bits [15:0] are used
- memwrite  in  1  store strobe for the current instruction
- memread  in  1  load strobe for the current instruction (CPU MemtoReg)
- pulse_in  in  2  asynchronous external count inputs, bit n feeds channel n
- hit  out  1  combinational: addr[31:5]==BASE_ADDR[31:5] and addr[4:2]<=5
- rdata  out  32  combinational read data; 0 when not hit; bits [31:16] are always 0
- irq  out  1  registered: OR over channels of done_n & ie_n

## Operation
- Register map (word offsets from BASE_ADDR):
  - +0x00 CTRL0 (write) / STATUS0 (read)
  - +0x04 CTRL1 (write) / STATUS1 (read)
  - +0x08 LOAD0 (read and write)
  - +0x0C LOAD1 (read and write)
  - +0x10 COUNT0 (read only)
  - +0x14 COUNT1 (read only)
  - Writes to COUNT offsets and to unmapped offsets are ignored.
- CTRL bits:
  - [0] en
  - [1] mode: 0 = timer, 1 = counter
  - [2] repeat
  - [3] ie
- STATUS bits:
  - [0] done (sticky)
  - [1] running
  - [2] mode
  - [3] repeat
- Per-channel state: load[15:0], count[15:0], mode, repeat, ie, running, done.
- CTRL write with en=1 (start):
  - Captures mode, repeat and ie.
  - Sets count<=load and running<=1.
  - If load==0, sets count<=0, running<=0, done<=1 instead.
- CTRL write with en=0 (stop): running<=0, count holds, done unchanged, mode/repeat/ie updated.
- CTRL write while running restarts the channel from the current LOAD value.
- Tick source:
  - Timer mode: one tick every clock while running.
  - Counter mode: one tick per rising edge of pulse_in[n], after a 2-flop synchroniser plus an edge-detect register.
- On a tick with running=1:
  - count>1: count<=count-1.
  - count==1: done<=1. If repeat, count<=load (LOAD value current at that edge) and running stays 1; otherwise count<=0 and running<=0.
- LOAD write while running does not touch count; it takes effect at the next reload or start.
- A load from a STATUS offset (memread & hit & offset 0x00/0x04) clears that channel's done at the clock edge ending the access.
- Same-edge done set and clear-on-read: set wins, done stays 1.
- Same-edge CTRL start and tick: the start wins, and the tick is discarded.
- memwrite and memread both high on a STATUS/CTRL offset: the write is performed and done is also cleared.

## Timing
- Reset values:
  - load=0, count=0, running=0, done=0, mode=0, repeat=0, ie=0 for both channels.
  - Synchroniser and edge registers are 0.
  - irq=0.
  - rdata and hit follow addr combinationally (0 for non-hit).
- Reset mid-count clears everything at that edge; no done or irq is produced.
- Read latency: 0 cycles, so rdata is valid in the same cycle addr/memread are presented.
- Timer mode: start at edge E with load=N (N>=1) gives done=1 after edge E+N and irq=1 after edge E+N+1 (if ie).
- Counter mode: a pulse_in rise sampled at edge k produces its tick at edge k+3.
- Counter mode: pulse_in must stay high and low >=2 clocks each to be counted.
- Repeat timer with load=N asserts done every N clocks; it does not drift.
- Count arithmetic is 16-bit unsigned. No underflow is possible, because count==1 is the terminal step.

## Test plan
- Reset, then read all 6 offsets -> rdata=0. A non-hit address 0x0000_0010 -> hit=0, rdata=0.
- LOAD0=5, CTRL0=0x9 (en, ie) at edge E -> COUNT0 reads 5,4,3,2,1 on successive cycles; done0=1 and COUNT0=0 after E+5; irq=1 after E+6. Read STATUS0 returns 0x1 and clears done0; irq falls on the next edge.
- LOAD1=3, CTRL1=0x7 (en, counter, repeat); apply 7 pulses on pulse_in[1] of 4 clocks high and 4 low -> done1 set after pulses 3 and 6; COUNT1=2 at the end; running1 stays 1.
- Repeat timer LOAD0=4. Write LOAD0=2 mid-count -> the current period still ends at 4 ticks; the following periods are 2 ticks.
- Read STATUS0 on the exact cycle count0 goes 1->0 -> done0 remains 1. CTRL0 rewritten mid-count -> count0 restarts from LOAD0 with no done.
- Assert reset for one cycle with channel 0 at count=3 -> all state and irq are 0 on the next cycle; no done is generated afterwards.
